mul_seq_ctrl: RTL and testbench

- Sequencer and two-way arbiter for the digit-serial GF(2^163) multiplier. The datapath is the 41-bit-digit partial-product generators, the accumulator, and reduction245.
- Shares one multiplier between two requesters, for example the point-add and point-double units.
- Owns the operand registers, the B-digit schedule, the accumulator feedback register and the result register.
- Each multiply takes two RUN cycles. Each RUN cycle processes two digits, MSB-first.

---
 rtl/mul_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_mul_seq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// Sequencer and two-way arbiter for the digit-serial GF(2^163) multiplier.
// Owns the operand registers, the B-digit schedule, the accumulator feedback
// register and the result register. Each multiply spends two RUN cycles,
// each feeding two 41-bit digits of B (MSB pair first) to the datapath.
//
// Handshakes: a transfer happens on a rising edge where VALID and READY are
// both high; READY is only ever high in IDLE for the arbitration winner, and
// Rn_RSP_VALID stays high with RSP_D stable until the matching Rn_RSP_READY.
module mul_seq_ctrl #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         R0_VALID,
  input  logic [162:0] R0_A,
  input  logic [162:0] R0_B,
  output logic         R0_READY,
  input  logic         R1_VALID,
  input  logic [162:0] R1_A,
  input  logic [162:0] R1_B,
  output logic         R1_READY,
  output logic         R0_RSP_VALID,
  output logic         R1_RSP_VALID,
  input  logic         R0_RSP_READY,
  input  logic         R1_RSP_READY,
  output logic [162:0] RSP_D,
  output logic [162:0] MUL_A,
  output logic [40:0]  MUL_DIG_LO,
  output logic [40:0]  MUL_DIG_HI,
  output logic [162:0] ACC_C_FB,
  input  logic [162:0] ACC_D_IN,
  output logic         BUSY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN0 = 2'd1,
    S_RUN1 = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [162:0] a_q, b_q, acc_q, res_q;
  logic         gnt_q;   // 0 = requester 0 owns the current operation
  logic         last_q;  // requester granted most recently (tie breaker)
  logic         win0, win1;
  logic         req_hs, rsp_hs;

  // Arbitration: sole requester wins; ties go to fixed R0 or the one not granted last.
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (R0_VALID && R1_VALID) begin
      if (FIXED_PRIO || last_q) win0 = 1'b1;
      else                      win1 = 1'b1;
    end else begin
      win0 = R0_VALID;
      win1 = R1_VALID;
    end
  end

  assign req_hs = (state_q == S_IDLE) && (win0 || win1);
  assign rsp_hs = (state_q == S_DONE) && (gnt_q ? R1_RSP_READY : R0_RSP_READY);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: IDLE -> RUN0 -> RUN1 -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_hs) state_d = S_RUN0;
      S_RUN0:  state_d = S_RUN1;
      S_RUN1:  state_d = S_DONE;
      S_DONE:  if (rsp_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: handshakes, busy flag and the per-state digit schedule.
  always_comb begin
    R0_READY     = 1'b0;
    R1_READY     = 1'b0;
    R0_RSP_VALID = 1'b0;
    R1_RSP_VALID = 1'b0;
    MUL_DIG_HI   = '0;
    MUL_DIG_LO   = '0;
    BUSY         = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        R0_READY = win0;
        R1_READY = win1;
      end
      S_RUN0: begin
        MUL_DIG_HI = {1'b0, b_q[162:123]};
        MUL_DIG_LO = b_q[122:82];
      end
      S_RUN1: begin
        MUL_DIG_HI = b_q[81:41];
        MUL_DIG_LO = b_q[40:0];
      end
      S_DONE: begin
        R0_RSP_VALID = ~gnt_q;
        R1_RSP_VALID = gnt_q;
      end
      default: ;
    endcase
  end

  // Operand capture, grant bookkeeping, accumulator feedback and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      res_q  <= '0;
      gnt_q  <= 1'b0;
      last_q <= 1'b1;
    end else begin
      if (req_hs) begin
        a_q    <= win1 ? R1_A : R0_A;
        b_q    <= win1 ? R1_B : R0_B;
        gnt_q  <= win1;
        last_q <= win1;
        acc_q  <= '0;
      end
      if (state_q == S_RUN0) acc_q <= ACC_D_IN;
      if (state_q == S_RUN1) res_q <= ACC_D_IN;
    end
  end

  assign MUL_A    = a_q;
  assign ACC_C_FB = acc_q;
  assign RSP_D    = res_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: a behavioural GF(2^163) datapath closes the
// accumulator loop, directed requests feed an expected-response queue, and a
// monitor pops and compares on every response handshake.
module tb_mul_seq_ctrl;

  localparam logic [244:0] POLY = (245'd1 << 163) | 245'hC9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (round-robin) ----------------
  logic         r0_valid = 1'b0, r1_valid = 1'b0;
  logic [162:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
  logic         r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid;
  logic         r0_rsp_ready = 1'b1, r1_rsp_ready = 1'b1;
  logic [162:0] rsp_d, mul_a, acc_c_fb, acc_d_in;
  logic [40:0]  dig_lo, dig_hi;
  logic         busy;

  mul_seq_ctrl #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .R0_VALID(r0_valid), .R0_A(r0_a), .R0_B(r0_b), .R0_READY(r0_ready),
    .R1_VALID(r1_valid), .R1_A(r1_a), .R1_B(r1_b), .R1_READY(r1_ready),
    .R0_RSP_VALID(r0_rsp_valid), .R1_RSP_VALID(r1_rsp_valid),
    .R0_RSP_READY(r0_rsp_ready), .R1_RSP_READY(r1_rsp_ready),
    .RSP_D(rsp_d), .MUL_A(mul_a), .MUL_DIG_LO(dig_lo), .MUL_DIG_HI(dig_hi),
    .ACC_C_FB(acc_c_fb), .ACC_D_IN(acc_d_in), .BUSY(busy)
  );

  // ---------------- second DUT (fixed priority), grants only ----------------
  logic         q_r0_valid = 1'b0, q_r1_valid = 1'b0;
  logic         q_r0_ready, q_r1_ready, q_r0_rsp_valid, q_r1_rsp_valid, q_busy;
  logic [162:0] q_rsp_d, q_mul_a, q_acc_c_fb;
  logic [40:0]  q_dig_lo, q_dig_hi;

  mul_seq_ctrl #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .R0_VALID(q_r0_valid), .R0_A('0), .R0_B('0), .R0_READY(q_r0_ready),
    .R1_VALID(q_r1_valid), .R1_A('0), .R1_B('0), .R1_READY(q_r1_ready),
    .R0_RSP_VALID(q_r0_rsp_valid), .R1_RSP_VALID(q_r1_rsp_valid),
    .R0_RSP_READY(1'b1), .R1_RSP_READY(1'b1),
    .RSP_D(q_rsp_d), .MUL_A(q_mul_a), .MUL_DIG_LO(q_dig_lo), .MUL_DIG_HI(q_dig_hi),
    .ACC_C_FB(q_acc_c_fb), .ACC_D_IN('0), .BUSY(q_busy)
  );

  // ---------------- datapath model ----------------
  function automatic logic [244:0] clmul(input logic [162:0] a, input logic [40:0] d);
    logic [244:0] r = '0;
    for (int i = 0; i < 41; i++)
      if (d[i]) r = r ^ ({82'b0, a} << i);
    return r;
  endfunction

  function automatic logic [162:0] red(input logic [244:0] v);
    logic [244:0] t = v;
    for (int i = 244; i >= 163; i--)
      if (t[i]) t = t ^ (POLY << (i - 163));
    return t[162:0];
  endfunction

  always_comb
    acc_d_in = red(clmul(mul_a, dig_lo) ^ (clmul(mul_a, dig_hi) << 41) ^ ({82'b0, acc_c_fb} << 82));

  function automatic logic [162:0] xp(input int n);
    return 163'd1 << n;
  endfunction

  // ---------------- scoreboard ----------------
  logic [163:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [244:0] act, input logic [244:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare on each response handshake (sampled after the falling edge).
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (r0_rsp_valid || r1_rsp_valid)
        chk("rsp_valid_excl", r0_rsp_valid && r1_rsp_valid, 1'b0);
      if ((r0_rsp_valid && r0_rsp_ready) || (r1_rsp_valid && r1_rsp_ready)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_unexpected: got id %0d data %0h with empty queue", r1_rsp_valid, rsp_d);
        end else begin
          chk("rsp_id_data", {r1_rsp_valid, rsp_d}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit id, input logic [162:0] a, input logic [162:0] b);
    if (id) begin r1_valid = 1'b1; r1_a = a; r1_b = b; end
    else    begin r0_valid = 1'b1; r0_a = a; r0_b = b; end
  endtask

  // Returns how many extra cycles passed before READY; handshake is the next edge.
  task automatic wait_ready(input bit id, output int n);
    n = 0;
    #1;
    while (!(id ? r1_ready : r0_ready) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("ready_seen", id ? r1_ready : r0_ready, 1'b1);
  endtask

  // Follows an accepted operation through RUN0, RUN1 and into DONE.
  task automatic follow(input bit id, input logic [162:0] a, input logic [162:0] b);
    @(negedge clk);
    if (id) r1_valid = 1'b0; else r0_valid = 1'b0;
    #1;
    chk("busy_run0", busy, 1'b1);
    chk("mul_a", mul_a, a);
    chk("dig_hi_run0", dig_hi, {1'b0, b[162:123]});
    chk("dig_lo_run0", dig_lo, b[122:82]);
    chk("acc_fb_run0", acc_c_fb, '0);
    chk("rsp_valid_run0", id ? r1_rsp_valid : r0_rsp_valid, 1'b0);
    @(negedge clk);
    #1;
    chk("dig_hi_run1", dig_hi, b[81:41]);
    chk("dig_lo_run1", dig_lo, b[40:0]);
    chk("rsp_valid_run1", id ? r1_rsp_valid : r0_rsp_valid, 1'b0);
    @(negedge clk);
    #1;
    chk("rsp_valid_done", id ? r1_rsp_valid : r0_rsp_valid, 1'b1);
    chk("rsp_valid_other", id ? r0_rsp_valid : r1_rsp_valid, 1'b0);
    chk("dig_hi_done", dig_hi, '0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic op(input bit id, input logic [162:0] a, input logic [162:0] b,
                    input logic [162:0] p);
    int n;
    exp_q.push_back({id, p});
    @(negedge clk);
    drive(id, a, b);
    wait_ready(id, n);
    chk("ready_latency", n, 0);
    follow(id, a, b);
    wait_drain();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, g, g0, g1;
    logic [162:0] p_x100sq, p_x162sq;
    p_x100sq = xp(44) | xp(43) | xp(40) | xp(37);        // x^200 mod f
    p_x162sq = xp(161) | xp(12) | xp(10) | xp(5) | xp(1); // x^324 mod f

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", {r0_ready, r1_ready}, 2'b00);
    chk("rst_rsp_valid", {r0_rsp_valid, r1_rsp_valid}, 2'b00);
    chk("rst_rsp_d", rsp_d, '0);
    chk("rst_mul_a", mul_a, '0);
    chk("rst_digits", {dig_hi, dig_lo}, '0);

    // Basic products, including reduction and both ends of the digit schedule.
    op(1'b0, 163'd1, 163'd1, 163'd1);
    op(1'b1, xp(162), xp(1), 163'hC9);
    op(1'b0, xp(1), xp(162), 163'hC9);

    // Response back-pressure, with R1 waiting behind the stalled response.
    r0_rsp_ready = 1'b0;
    exp_q.push_back({1'b0, xp(162)});
    @(negedge clk);
    drive(1'b0, xp(81), xp(81));
    wait_ready(1'b0, n);
    follow(1'b0, xp(81), xp(81));
    drive(1'b1, xp(162), xp(162));
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("hold_rsp_valid", r0_rsp_valid, 1'b1);
      chk("hold_rsp_d", rsp_d, xp(162));
      chk("hold_busy", busy, 1'b1);
      chk("hold_r1_ready", r1_ready, 1'b0);
    end
    @(negedge clk);
    r0_rsp_ready = 1'b1;
    #1;
    chk("release_r1_ready", r1_ready, 1'b0);
    exp_q.push_back({1'b1, p_x162sq});
    @(negedge clk);
    #1;
    chk("after_release_r1_ready", r1_ready, 1'b1);
    follow(1'b1, xp(162), xp(162));
    wait_drain();

    // Round-robin with both requesters held for six operations (R1 granted last).
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, 163'hF});
      exp_q.push_back({1'b1, p_x100sq});
    end
    @(negedge clk);
    drive(1'b0, 163'd3, 163'd5);
    drive(1'b1, xp(100), xp(100));
    g = 0;
    for (int i = 0; i < 40 && g < 6; i++) begin
      #1;
      if (r0_ready || r1_ready) begin
        chk("one_ready", r0_ready && r1_ready, 1'b0);
        g++;
      end
      if (g < 6) @(negedge clk);
    end
    chk("rr_grants", g, 6);
    @(negedge clk);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    wait_drain();

    // Reset during RUN1 drops the operation; the held request is served afresh.
    @(negedge clk);
    drive(1'b0, xp(2), xp(162));
    wait_ready(1'b0, n);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rrst_busy", busy, 1'b0);
    chk("rrst_rsp_valid", {r0_rsp_valid, r1_rsp_valid}, 2'b00);
    chk("rrst_rsp_d", rsp_d, '0);
    chk("rrst_mul_a", mul_a, '0);
    chk("rrst_acc_fb", acc_c_fb, '0);
    chk("rrst_digits", {dig_hi, dig_lo}, '0);
    chk("rrst_ready", r0_ready, 1'b1);
    exp_q.push_back({1'b0, xp(8) | xp(7) | xp(4) | xp(1)});
    follow(1'b0, xp(2), xp(162));
    wait_drain();

    // Fixed priority: R0 wins every tie, R1 starves.
    @(negedge clk);
    q_r0_valid = 1'b1;
    q_r1_valid = 1'b1;
    g0 = 0;
    g1 = 0;
    repeat (24) begin
      #1;
      if (q_r0_ready) g0++;
      if (q_r1_ready) g1++;
      @(negedge clk);
    end
    q_r0_valid = 1'b0;
    q_r1_valid = 1'b0;
    chk("fp_r0_grants", g0, 6);
    chk("fp_r1_grants", g1, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
